pll_reset_ctrl: RTL
===================

Name: pll_reset_ctrl

Overview:
Sequencer for the board PLL (Gowin_PLL_ext) that drives the PLL RESET pin, qualifies LOCK and releases the system reset only after lock has been stable.
Runs on the free-running 50 MHz board input clock, not on a PLL output.
Detects loss of lock and automatically re-runs the reset/lock sequence.
Its sys_resetn_o feeds the per-domain reset synchronizers for clkout0/clkout1.

Parameters:
RST_CYCLES, 16, cycles pll_reset_o is held high per reset attempt (≥2)
LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before retrying (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release (≥1)
CNT_W, 20, width of the shared phase counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1
MAX_RETRY, 4, consecutive timeouts before FAIL (used only with the optional feature)

Ports:
clk  in  1  board reference clock (50 MHz, free-running)
resetn  in  1  asynchronous active-low reset
pll_lock_i  in  1  PLL LOCK; asynchronous to clk
soft_rst_req  in  1  single-cycle request to re-run the sequence
pll_reset_o  out  1  to PLL RESET; active high
sys_resetn_o  out  1  system reset; low until lock is qualified
locked_o  out  1  high only in RUN
state_o  out  3  current state encoding
relock_cnt_o  out  8  lock-loss events seen in RUN; saturates at 255
fail_o  out  1  retry limit exhausted; always 0 without the macro

Behaviour:
- Reset (resetn=0), all outputs registered:
  - state=RST_ASSERT(0), counter=0
  - pll_reset_o=1, sys_resetn_o=0, locked_o=0
  - relock_cnt_o=0, retry count=0, fail_o=0
- Synchronizer: pll_lock_i passes through a 2-flop synchronizer to give lock_s (2 cycles latency). The FSM uses only lock_s.
- States and encodings: RST_ASSERT=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- Counter: cleared on every state change; otherwise increments.
- RST_ASSERT:
  - pll_reset_o=1.
  - When counter==RST_CYCLES-1, go to WAIT_LOCK.
  - pll_reset_o is high exactly RST_CYCLES cycles per attempt.
- WAIT_LOCK:
  - pll_reset_o=0.
  - If lock_s=1, go to STABLE.
  - Else if counter==LOCK_TIMEOUT-1, go to RST_ASSERT and increment the retry count.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK; the timeout restarts.
  - Else if counter==STABLE_CYCLES-1, go to RUN and clear the retry count.
- RUN:
  - sys_resetn_o=1, locked_o=1.
  - If lock_s=0, go to RST_ASSERT and increment relock_cnt_o (saturating).
- Output timing:
  - sys_resetn_o and locked_o are registered from next-state, so they change on the same edge the state changes.
  - Latency from the first edge sampling pll_lock_i=1 (while in WAIT_LOCK) to sys_resetn_o=1 is exactly STABLE_CYCLES+3 edges.
- soft_rst_req=1 in any state: go to RST_ASSERT on the next edge. This has highest priority over every other transition.
  - If it coincides with lock loss in RUN, relock_cnt_o is not incremented.
  - It clears the retry count and fail_o.
- sys_resetn_o asserts low on the same edge RUN is left. There is no glitch to high outside RUN.
- resetn mid-sequence: immediate asynchronous return to the reset values. relock_cnt_o is lost.

Optional Feature:
PLL_RETRY_LIMIT_EN
- Defined: when the retry count reaches MAX_RETRY on a WAIT_LOCK timeout, go to FAIL instead of RST_ASSERT.
  - FAIL holds pll_reset_o=1, sys_resetn_o=0 and fail_o=1.
  - FAIL exits only via soft_rst_req (to RST_ASSERT) or resetn.
- Undefined: retries forever; FAIL is unreachable; fail_o is tied 0; the retry counter is not synthesized.

Decomposition:
- Package pll_ctrl_pkg: state encodings (3-bit constants RST_ASSERT..FAIL) and the relock counter width (8).
- Sub-module sync_2ff (generic 2-flop synchronizer, async active-low reset to 0), instantiated once for pll_lock_i.
- The FSM, counter and output registers stay in pll_reset_ctrl.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
1. Release resetn; raise pll_lock_i 3 cycles after WAIT_LOCK entry -> pll_reset_o high exactly 4 cycles; sys_resetn_o rises exactly 11 edges after lock is first sampled; locked_o=1, state_o=3.
2. Hold pll_lock_i=0 -> pll_reset_o re-pulses for 4 cycles every 24 cycles; sys_resetn_o stays 0; with the macro, FAIL is entered after the 2nd timeout, fail_o=1 and pll_reset_o=1 are held.
3. In STABLE, drop lock for 1 cycle at count 5 -> returns to WAIT_LOCK; the full 8-cycle stable window is needed again; no early release.
4. In RUN, drop pll_lock_i -> sys_resetn_o=0 and locked_o=0 within 3 edges; relock_cnt_o=1; relock completes normally. Repeat 300 times -> relock_cnt_o stays at 255.
5. In RUN, assert soft_rst_req on the same cycle lock_s falls -> RST_ASSERT; relock_cnt_o unchanged. From FAIL, soft_rst_req -> fail_o=0 and the sequence restarts.
6. Assert resetn=0 asynchronously mid-STABLE -> all outputs at reset values immediately without a clock edge; pll_reset_o=1.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL reset/lock sequencer: state encodings and
// the relock event counter width.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_ASSERT = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        FAIL       = 3'd4
    } pll_state_e;

    localparam int unsigned RELOCK_W = 8;

    // Saturating increment so the lock-loss count sticks at all-ones.
    function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
        return (&v) ? v : v + RELOCK_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow or level signals crossing into clk.
// Both stages clear to 0 on the asynchronous active-low reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock sequencer on the free-running board clock: pulses PLL RESET, qualifies
// LOCK and releases sys_resetn_o. Optional retry limit via `define PLL_RETRY_LIMIT_EN.
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned MAX_RETRY     = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pll_lock_i,
    input  logic                soft_rst_req,
    output logic                pll_reset_o,
    output logic                sys_resetn_o,
    output logic                locked_o,
    output logic [2:0]          state_o,
    output logic [RELOCK_W-1:0] relock_cnt_o,
    output logic                fail_o
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    pll_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                pll_reset_q, pll_reset_d;
    logic                sys_resetn_q, sys_resetn_d;
    logic                locked_q, locked_d;
    logic                lock_s;
    logic                retry_inc;
    logic                retry_clr;
    logic                retry_exhausted;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_lock_i),
        .q      (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        relock_d  = relock_q;
        retry_inc = 1'b0;
        retry_clr = 1'b0;

        if (soft_rst_req) begin
            // Overrides every other transition, including a coincident lock loss in RUN.
            state_d   = RST_ASSERT;
            retry_clr = 1'b1;
        end else begin
            unique case (state_q)
                RST_ASSERT: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_inc = 1'b1;
                        state_d   = retry_exhausted ? FAIL : RST_ASSERT;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d   = RUN;
                        retry_clr = 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d  = RST_ASSERT;
                        relock_d = sat_inc(relock_q);
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RST_ASSERT;
                end
            endcase
        end

        // A soft request in RST_ASSERT keeps the state but must still restart the pulse.
        cnt_d = ((state_d != state_q) || soft_rst_req) ? '0 : cnt_q + CNT_W'(1);

        // Outputs follow the next state so they switch on the same edge as state_q.
        pll_reset_d  = (state_d == RST_ASSERT) || (state_d == FAIL);
        sys_resetn_d = (state_d == RUN);
        locked_d     = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RST_ASSERT;
            cnt_q        <= '0;
            relock_q     <= '0;
            pll_reset_q  <= 1'b1;
            sys_resetn_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            relock_q     <= relock_d;
            pll_reset_q  <= pll_reset_d;
            sys_resetn_q <= sys_resetn_d;
            locked_q     <= locked_d;
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    logic [RETRY_W-1:0] retry_q;
    logic               fail_q;

    // This timeout is the one that brings the count up to MAX_RETRY.
    assign retry_exhausted = (retry_q == RETRY_W'(MAX_RETRY - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retry_q <= '0;
            fail_q  <= 1'b0;
        end else begin
            if (retry_clr) begin
                retry_q <= '0;
            end else if (retry_inc) begin
                retry_q <= retry_q + RETRY_W'(1);
            end
            fail_q <= (state_d == FAIL);
        end
    end

    assign fail_o = fail_q;
`else
    logic unused_retry;

    assign retry_exhausted = 1'b0;
    assign unused_retry    = ^{retry_inc, retry_clr, MAX_RETRY};
    assign fail_o          = 1'b0;
`endif

    assign pll_reset_o  = pll_reset_q;
    assign sys_resetn_o = sys_resetn_q;
    assign locked_o     = locked_q;
    assign state_o      = state_q;
    assign relock_cnt_o = relock_q;

endmodule
